axis_sample_packer: RTL and testbench
=====================================

// Module: axis_sample_packer
// PURPOSE
//  Upstream stage of the forward-path AXIS buffer. Takes a narrow stream of fixed-point samples from the DMA
//  MM2S side or a preprocessing core. Packs LANES samples into each 64-bit word and frames every WORDS_PER_PKT
//  words as one packet, asserting tlast on the final word. The output feeds the 64-bit slave port of the
//  forward/buffer block directly.
// PARAMETERS
//  SAMPLE_W       16  width of one input sample
//  LANES           4  samples per output word; DATA_W = SAMPLE_W*LANES (must equal 64)
//  WORDS_PER_PKT   5  output words per packet; tlast on word WORDS_PER_PKT-1
// PORTS
//  aclk           in   1         clock, all logic rising edge
//  aresetn        in   1         asynchronous active-low reset
//  s_axis_tready  out  1         sample accepted when tvalid&tready
//  s_axis_tdata   in   SAMPLE_W  input sample
//  s_axis_tvalid  in   1         sample valid
//  s_axis_tlast   in   1         end of source frame (used only with PACKER_FLUSH_EN)
//  m_axis_tready  in   1         downstream ready
//  m_axis_tdata   out  DATA_W    packed word, lane 0 in [SAMPLE_W-1:0]
//  m_axis_tvalid  out  1         word valid
//  m_axis_tlast   out  1         last word of packet
//  pkt_count      out  16        packets emitted (tlast handshakes), wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset (async, any time): state=FILL, lane_cnt=0, word_cnt=0, assembly reg cleared, m_axis_tvalid=0,
//    m_axis_tlast=0, m_axis_tdata=0, pkt_count=0, s_axis_tready=0 during reset, 1 from the first clock edge after
//    release. A partial word or packet in progress is discarded.
//  - Lane order: the k-th accepted sample of a word goes to bits [k*SAMPLE_W +: SAMPLE_W].
//  - States: FILL: s_axis_tready=1, collecting samples. HOLD: complete word parked in the assembly reg,
//    s_axis_tready=0.
//  - s_axis_tready is driven from state only; there is no combinational path from m_axis_tready.
//  - FILL, accept with lane_cnt<LANES-1: write lane, lane_cnt++.
//  - FILL, accept with lane_cnt==LANES-1: the word is complete and lane_cnt returns to 0.
//    - If the output reg is empty, or drains this cycle (m_tvalid&m_tready), the word loads into the output reg
//      at this edge. m_axis_tvalid=1 next cycle, so latency is 1 cycle from the last sample to the word.
//    - Otherwise go to HOLD.
//  - HOLD: when the output reg drains (m_tvalid&m_tready), the parked word moves to the output reg at the same
//    edge and the state returns to FILL.
//  - Output reg obeys AXIS: tdata/tlast stay stable while tvalid&!tready; tvalid drops only after a handshake
//    with no new word loaded.
//  - m_axis_tlast=1 on a word loaded when word_cnt==WORDS_PER_PKT-1. word_cnt increments per word loaded into
//    the output reg and wraps to 0 after the tlast word.
//  - pkt_count increments on each m_tvalid&m_tready&m_tlast.
//  - Throughput: 1 sample/cycle sustained while downstream is ready; a blocked sink stalls the source only
//    after one complete word is parked.
// CONFIGURATION
//  PACKER_FLUSH_EN defined:
//  - A sample accepted with s_axis_tlast=1 closes the current word. Unfilled higher lanes are zero-padded.
//  - That word carries m_axis_tlast=1 regardless of word_cnt. word_cnt and lane_cnt reset to 0 afterwards.
//  - Load/HOLD rules are as for a complete word.
//  PACKER_FLUSH_EN undefined:
//  - s_axis_tlast is ignored.
//  - Framing is purely count-based: LANES samples per word, WORDS_PER_PKT words per packet.
// TESTING
//  1. Reset, m_tready=1, feed samples 0x0001..0x0014 back-to-back -> 5 words. Word0=0x0004_0003_0002_0001,
//     tlast only on word4=0x0014_0013_0012_0011, pkt_count=1.
//  2. m_tready=0, feed 12 samples -> word0 in the output reg, word1 parked (HOLD). s_tready=0 after the 8th sample
//     and stays 0. Raise m_tready -> words 0,1,2 in order, nothing lost.
//  3. Assert aresetn=0 after 6 samples (mid-word) -> all outputs reset immediately. The next 20 samples produce a
//     clean packet with lane 0 = first post-reset sample.
//  4. m_tready toggling 1/0 every cycle over 3 packets -> tdata/tlast stable while stalled. Exactly 3 tlast beats,
//     pkt_count=3.
//  5. PACKER_FLUSH_EN: 6 samples, 6th with tlast -> word1=0x0000_0000_0006_0005 with tlast=1. The next word starts a
//     fresh packet, with tlast after 5 more words.
//  6. No PACKER_FLUSH_EN, same stimulus -> tlast ignored, word1 not emitted until 2 more samples arrive, tlast=0.

Source files
------------

// File: rtl/axis_sample_packer_if.sv
// AXI4-Stream bundle (tdata/tvalid/tready/tlast) shared by the packer's input and output sides.
// Latency: none, wires only.
// Backpressure: carries tready from the slave back to the master.
interface axis_sample_packer_if #(
    parameter int W = 64
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_sample_packer.sv
// Packs LANES narrow samples per 64-bit word and frames WORDS_PER_PKT words per packet (tlast on the last word).
// Latency: 1 cycle from the last sample of a word to the word appearing on the output.
// Backpressure: one complete word can park while the output is stalled; after that s_axis.tready drops until the output drains.
// Optional feature: define PACKER_FLUSH_EN so an input tlast closes the word early (zero-padded) and ends the packet.
module axis_sample_packer #(
    parameter int SAMPLE_W      = 16,
    parameter int LANES         = 4,
    parameter int WORDS_PER_PKT = 5
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axis_sample_packer_if.slave      s_axis,
    axis_sample_packer_if.master     m_axis,
    output logic [15:0]              pkt_count
);
    localparam int DATA_W = SAMPLE_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WCNT_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic                live_q;        // low until the first edge after reset release
    logic [LANE_W-1:0]   lane_q;
    logic [WCNT_W-1:0]   word_cnt_q;
    logic [DATA_W-1:0]   asm_q;         // word under assembly, or the parked word in HOLD
    logic                hold_flush_q;  // parked word was closed by an input tlast
    logic [DATA_W-1:0]   out_dat_q;
    logic                out_vld_q;
    logic                out_lst_q;

    logic                s_rdy;
    logic                accept;
    logic                drain;
    logic                out_free;
    logic                flush_req;
    logic                word_done;
    logic                load;
    logic                load_hold;
    logic                load_lst;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   load_dat;

`ifdef PACKER_FLUSH_EN
    assign flush_req = accept && s_axis.tlast;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
    assign flush_req    = 1'b0;
`endif

    assign s_axis.tready = s_rdy;
    assign m_axis.tdata  = out_dat_q;
    assign m_axis.tvalid = out_vld_q;
    assign m_axis.tlast  = out_lst_q;

    // Next state and datapath steering; ready depends only on registered state.
    always_comb begin
        state_d   = state_q;
        s_rdy     = live_q && (state_q == FILL);
        accept    = s_axis.tvalid && s_rdy;
        drain     = out_vld_q && m_axis.tready;
        out_free  = !out_vld_q || m_axis.tready;
        word_done = accept && ((lane_q == LANE_W'(LANES - 1)) || flush_req);
        merged    = asm_q;
        merged[lane_q * SAMPLE_W +: SAMPLE_W] = s_axis.tdata;
        load_hold = (state_q == HOLD) && drain;
        load      = (word_done && out_free) || load_hold;
        load_dat  = load_hold ? asm_q : merged;
        load_lst  = (load_hold ? hold_flush_q : flush_req) ||
                    (word_cnt_q == WCNT_W'(WORDS_PER_PKT - 1));
        case (state_q)
            FILL: if (word_done && !out_free) state_d = HOLD;
            HOLD: if (drain)                  state_d = FILL;
            default:                          state_d = FILL;
        endcase
    end

    // State register plus the post-reset enable for s_axis.tready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= FILL;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // Lane fill, word assembly and parking of a complete word while the output is blocked.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane_q       <= '0;
            asm_q        <= '0;
            hold_flush_q <= 1'b0;
        end else begin
            if (word_done) begin
                lane_q <= '0;
                asm_q  <= out_free ? '0 : merged;
                if (!out_free) hold_flush_q <= flush_req;
            end else if (accept) begin
                lane_q <= lane_q + 1'b1;
                asm_q  <= merged;
            end else if (load_hold) begin
                asm_q        <= '0;
                hold_flush_q <= 1'b0;
            end
        end
    end

    // Output register and packet framing; contents hold steady while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            out_lst_q  <= 1'b0;
            word_cnt_q <= '0;
        end else if (load) begin
            out_dat_q  <= load_dat;
            out_vld_q  <= 1'b1;
            out_lst_q  <= load_lst;
            word_cnt_q <= load_lst ? '0 : word_cnt_q + 1'b1;
        end else if (drain) begin
            out_vld_q  <= 1'b0;
        end
    end

    // Count packets leaving on the output (tlast handshakes), wrapping naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else if (drain && out_lst_q) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed bench for axis_sample_packer: framing, parking, reset, stalls, optional flush.
// Latency: checks words appear one cycle after the last sample.
// Backpressure: drives m_axis.tready low/toggling and watches s_axis.tready and output stability.
module tb_axis_sample_packer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] pkt_count;

    axis_sample_packer_if #(.W(16)) s_if ();
    axis_sample_packer_if #(.W(64)) m_if ();

    axis_sample_packer dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if.slave),
        .m_axis    (m_if.master),
        .pkt_count (pkt_count)
    );

    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad   = 0;
    logic [64:0] beats[$];
    bit          toggle_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] prev_dat;
    logic        prev_lst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] b);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    // Output monitor: log handshakes, and require stable data while stalled.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_if.tvalid && m_if.tready) beats.push_back({m_if.tlast, m_if.tdata});
            if (stall_prev) begin
                check("stable_tdata", m_if.tdata, prev_dat);
                check("stable_tlast", {63'd0, m_if.tlast}, {63'd0, prev_lst});
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_dat   = m_if.tdata;
            prev_lst   = m_if.tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
        if (toggle_en) m_if.tready = ~m_if.tready;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            ok = s_if.tready;
            tick();
            if (ok) break;
        end
        if (!ok) check("send_timeout", {63'd0, ok}, 64'd1);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        for (int i = 0; i < 500 && beats.size() < n; i++) tick();
        check(tag, beats.size(), n);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        beats.delete();
        tick();
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // Reset values
        #1;
        check("rst_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        check("rst_tlast",  {63'd0, m_if.tlast},  64'd0);
        check("rst_tdata",  m_if.tdata, 64'd0);
        check("rst_pkt",    {48'd0, pkt_count}, 64'd0);
        check("rst_s_rdy",  {63'd0, s_if.tready}, 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        check("rel_s_rdy_lo", {63'd0, s_if.tready}, 64'd0);
        tick();
        check("rel_s_rdy_hi", {63'd0, s_if.tready}, 64'd1);

        // Test 1: one full packet back-to-back
        m_if.tready = 1'b1;
        for (int i = 1; i <= 20; i++) send(16'(i), 1'b0);
        wait_beats(5, "t1_beats");
        check("t1_word0", beats[0][63:0], 64'h0004_0003_0002_0001);
        check("t1_word4", beats[4][63:0], 64'h0014_0013_0012_0011);
        for (int k = 1; k < 4; k++) check("t1_word", beats[k][63:0], pack4(16'(4 * k + 1)));
        for (int k = 0; k < 5; k++) check("t1_tlast", {63'd0, beats[k][64]}, {63'd0, (k == 4)});
        tick();
        check("t1_pkt", {48'd0, pkt_count}, 64'd1);
        check("t1_idle", {63'd0, m_if.tvalid}, 64'd0);

        // Test 2: blocked sink, one word out, one parked, source stalls
        beats.delete();
        m_if.tready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h0021 + 16'(i), 1'b0);
        check("t2_s_rdy_lo", {63'd0, s_if.tready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_s_rdy_held", {63'd0, s_if.tready}, 64'd0);
        end
        check("t2_out_vld", {63'd0, m_if.tvalid}, 64'd1);
        check("t2_out_dat", m_if.tdata, pack4(16'h0021));
        m_if.tready = 1'b1;
        for (int i = 8; i < 12; i++) send(16'h0021 + 16'(i), 1'b0);
        wait_beats(3, "t2_beats");
        for (int k = 0; k < 3; k++) begin
            check("t2_word",  beats[k][63:0], pack4(16'h0021 + 16'(4 * k)));
            check("t2_tlast", {63'd0, beats[k][64]}, 64'd0);
        end

        // Test 3: reset mid-word discards partial state
        for (int i = 0; i < 6; i++) send(16'h0031 + 16'(i), 1'b0);
        aresetn = 1'b0;
        #1;
        check("t3_rst_vld",  {63'd0, m_if.tvalid}, 64'd0);
        check("t3_rst_dat",  m_if.tdata, 64'd0);
        check("t3_rst_lst",  {63'd0, m_if.tlast}, 64'd0);
        check("t3_rst_pkt",  {48'd0, pkt_count}, 64'd0);
        check("t3_rst_srdy", {63'd0, s_if.tready}, 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        beats.delete();
        tick();
        for (int i = 0; i < 20; i++) send(16'h0041 + 16'(i), 1'b0);
        wait_beats(5, "t3_beats");
        for (int k = 0; k < 5; k++) begin
            check("t3_word",  beats[k][63:0], pack4(16'h0041 + 16'(4 * k)));
            check("t3_tlast", {63'd0, beats[k][64]}, {63'd0, (k == 4)});
        end
        tick();
        check("t3_pkt", {48'd0, pkt_count}, 64'd1);

        // Test 4: sink ready toggling every cycle over three packets
        do_reset();
        m_if.tready = 1'b1;
        toggle_en   = 1'b1;
        for (int i = 0; i < 60; i++) send(16'h0101 + 16'(i), 1'b0);
        wait_beats(15, "t4_beats");
        toggle_en   = 1'b0;
        m_if.tready = 1'b1;
        begin
            int nlast;
            nlast = 0;
            for (int k = 0; k < 15; k++) begin
                check("t4_word",  beats[k][63:0], pack4(16'h0101 + 16'(4 * k)));
                check("t4_tlast", {63'd0, beats[k][64]}, {63'd0, (k % 5 == 4)});
                if (beats[k][64]) nlast++;
            end
            check("t4_nlast", nlast, 3);
        end
        tick();
        check("t4_pkt", {48'd0, pkt_count}, 64'd3);

        // Test 5/6: input tlast on the 6th sample
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 1; i <= 5; i++) send(16'(i), 1'b0);
        send(16'h0006, 1'b1);
`ifdef PACKER_FLUSH_EN
        wait_beats(2, "t5_beats");
        check("t5_word0",  beats[0][63:0], 64'h0004_0003_0002_0001);
        check("t5_tlast0", {63'd0, beats[0][64]}, 64'd0);
        check("t5_word1",  beats[1][63:0], 64'h0000_0000_0006_0005);
        check("t5_tlast1", {63'd0, beats[1][64]}, 64'd1);
        for (int i = 0; i < 20; i++) send(16'h0061 + 16'(i), 1'b0);
        wait_beats(7, "t5_beats_next");
        for (int k = 2; k < 7; k++) begin
            check("t5_word",  beats[k][63:0], pack4(16'h0061 + 16'(4 * (k - 2))));
            check("t5_tlast", {63'd0, beats[k][64]}, {63'd0, (k == 6)});
        end
        tick();
        check("t5_pkt", {48'd0, pkt_count}, 64'd2);
`else
        repeat (4) tick();
        check("t6_one_word", beats.size(), 1);
        check("t6_word0", beats[0][63:0], 64'h0004_0003_0002_0001);
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b0);
        wait_beats(2, "t6_beats");
        check("t6_word1", beats[1][63:0], 64'h0008_0007_0006_0005);
        check("t6_tlast", {63'd0, beats[1][64]}, 64'd0);
        tick();
        check("t6_pkt", {48'd0, pkt_count}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
